matmul_result_writeback: RTL and testbench

//  Downstream stage of the vector matmul unit. Accepts 2x2 result tiles (4 x 64-bit signed

---
 rtl/matmul_result_writeback.sv | 166 ++++++++++++++++
 tb/tb_matmul_result_writeback.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_writeback.sv
// Result write-back stage: narrows 2x2 accumulator tiles to 32-bit lanes, queues them and
// drains them to the VRF write port. Optional rounding before the shift: MATMUL_WB_ROUND_EN.
//
// state  | meaning
// IDLE   | no write-back in progress
// ACTIVE | tiles arriving/draining; waiting for producer done and an empty FIFO
// DONE   | write-back complete; wb_done_o pulses for this single cycle
module matmul_result_writeback #(
  parameter int VLEN       = 256,
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clear_i,
  input  logic [5:0]           cfg_shift_i,
  input  logic                 cfg_sat_en_i,
  input  logic                 res_valid_i,
  input  logic [4:0]           res_addr_i,
  input  logic [VLEN-1:0]      res_data_i,
  output logic                 res_ready_o,
  input  logic                 mm_done_i,
  output logic                 vrf_we_o,
  input  logic                 vrf_gnt_i,
  output logic [4:0]           vrf_waddr_o,
  output logic [VLEN-1:0]      vrf_wdata_o,
  output logic [VLEN/32-1:0]   vrf_wmask_o,
  output logic                 busy_o,
  output logic                 wb_done_o,
  output logic [7:0]           tile_count_o,
  output logic                 sat_flag_o,
  output logic                 drop_err_o
);

  localparam int LANES = 4;
  localparam int TW    = LANES * DATA_WIDTH;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int CW    = PW + 1;
  localparam int MW    = VLEN / 32;
`ifdef MATMUL_WB_ROUND_EN
  localparam int EW    = ACC_WIDTH + 1;
`else
  localparam int EW    = ACC_WIDTH;
`endif

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  state_t               state;
  logic                 done_seen;
  logic signed [EW-1:0] lane_ext [LANES];
  logic signed [EW-1:0] lane_shr [LANES];
  logic [LANES-1:0]     lane_clamp;
  logic [TW-1:0]        tile_nar;

  logic [4:0]           addr_mem [FIFO_DEPTH];
  logic [TW-1:0]        data_mem [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fill;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic                 drain_empty;

  // A lane overflows when the bits above the int32 sign bit are not all copies of it.
  always_comb begin
    tile_nar   = '0;
    lane_clamp = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_ext[i] = EW'($signed(res_data_i[i*ACC_WIDTH +: ACC_WIDTH]));
`ifdef MATMUL_WB_ROUND_EN
      if (cfg_shift_i != 6'd0) begin
        lane_ext[i] = lane_ext[i] + (EW'(1) << (cfg_shift_i - 6'd1));
      end
`endif
      lane_shr[i] = lane_ext[i] >>> cfg_shift_i;
      if (cfg_sat_en_i && (|lane_shr[i][EW-1:DATA_WIDTH-1])
          && !(&lane_shr[i][EW-1:DATA_WIDTH-1])) begin
        lane_clamp[i] = 1'b1;
        tile_nar[i*DATA_WIDTH +: DATA_WIDTH] = lane_shr[i][EW-1]
          ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
          : {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end else begin
        tile_nar[i*DATA_WIDTH +: DATA_WIDTH] = lane_shr[i][DATA_WIDTH-1:0];
      end
    end
  end

  assign full        = (fill == CW'(FIFO_DEPTH));
  assign vrf_we_o    = (fill != '0);
  assign pop         = vrf_we_o && vrf_gnt_i;
  assign res_ready_o = !full || pop;
  assign push        = res_valid_i && res_ready_o && !clear_i;
  assign drop        = res_valid_i && !res_ready_o && !clear_i;
  // Only used while res_valid_i is low, so a pop of the last entry means empty.
  assign drain_empty = (fill == '0) || ((fill == CW'(1)) && pop);

  assign vrf_waddr_o = vrf_we_o ? addr_mem[rd_ptr] : '0;
  assign vrf_wdata_o = vrf_we_o ? VLEN'(data_mem[rd_ptr]) : '0;
  assign vrf_wmask_o = MW'(4'b1111);
  assign busy_o      = (state != IDLE) || vrf_we_o;

  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_mem[wr_ptr] <= res_addr_i;
      data_mem[wr_ptr] <= tile_nar;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      done_seen    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      wb_done_o    <= 1'b0;
      tile_count_o <= '0;
      sat_flag_o   <= 1'b0;
      drop_err_o   <= 1'b0;
    end else if (clear_i) begin
      state        <= IDLE;
      done_seen    <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fill         <= '0;
      wb_done_o    <= 1'b0;
      tile_count_o <= '0;
      sat_flag_o   <= 1'b0;
      drop_err_o   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      fill <= fill + CW'(push) - CW'(pop);
      if (drop) drop_err_o <= 1'b1;
      if (push && (|lane_clamp)) sat_flag_o <= 1'b1;
      if (pop && (tile_count_o != 8'hFF)) tile_count_o <= tile_count_o + 8'd1;
      wb_done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (res_valid_i || mm_done_i) begin
            state        <= ACTIVE;
            tile_count_o <= '0;
            done_seen    <= mm_done_i;
          end
        end
        ACTIVE: begin
          if (mm_done_i) done_seen <= 1'b1;
          if (done_seen && drain_empty && !res_valid_i) begin
            state     <= DONE;
            wb_done_o <= 1'b1;
          end
        end
        DONE: begin
          done_seen <= 1'b0;
          state     <= res_valid_i ? ACTIVE : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_result_writeback.sv
// Directed self-checking bench for matmul_result_writeback (default build or MATMUL_WB_ROUND_EN).
module tb_matmul_result_writeback;

  logic         clk_i;
  logic         rst_ni;
  logic         clear_i;
  logic [5:0]   cfg_shift_i;
  logic         cfg_sat_en_i;
  logic         res_valid_i;
  logic [4:0]   res_addr_i;
  logic [255:0] res_data_i;
  logic         res_ready_o;
  logic         mm_done_i;
  logic         vrf_we_o;
  logic         vrf_gnt_i;
  logic [4:0]   vrf_waddr_o;
  logic [255:0] vrf_wdata_o;
  logic [7:0]   vrf_wmask_o;
  logic         busy_o;
  logic         wb_done_o;
  logic [7:0]   tile_count_o;
  logic         sat_flag_o;
  logic         drop_err_o;

  int total = 0;
  int bad   = 0;

  matmul_result_writeback dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .cfg_shift_i  (cfg_shift_i),
    .cfg_sat_en_i (cfg_sat_en_i),
    .res_valid_i  (res_valid_i),
    .res_addr_i   (res_addr_i),
    .res_data_i   (res_data_i),
    .res_ready_o  (res_ready_o),
    .mm_done_i    (mm_done_i),
    .vrf_we_o     (vrf_we_o),
    .vrf_gnt_i    (vrf_gnt_i),
    .vrf_waddr_o  (vrf_waddr_o),
    .vrf_wdata_o  (vrf_wdata_o),
    .vrf_wmask_o  (vrf_wmask_o),
    .busy_o       (busy_o),
    .wb_done_o    (wb_done_o),
    .tile_count_o (tile_count_o),
    .sat_flag_o   (sat_flag_o),
    .drop_err_o   (drop_err_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] lanes(input logic [63:0] a, input logic [63:0] b,
                                         input logic [63:0] c, input logic [63:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [255:0] exp4(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c, input logic [31:0] d);
    return {128'd0, d, c, b, a};
  endfunction

  // One-cycle result pulse; returns at the drive point of the following cycle.
  task automatic send(input logic [4:0] addr, input logic [255:0] data);
    res_valid_i = 1'b1;
    res_addr_i  = addr;
    res_data_i  = data;
    @(posedge clk_i); #1;
    res_valid_i = 1'b0;
    res_data_i  = '0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(posedge clk_i); #1;
    clear_i = 1'b0;
  endtask

  initial begin
    rst_ni       = 1'b0;
    clear_i      = 1'b0;
    cfg_shift_i  = '0;
    cfg_sat_en_i = 1'b0;
    res_valid_i  = 1'b0;
    res_addr_i   = '0;
    res_data_i   = '0;
    mm_done_i    = 1'b0;
    vrf_gnt_i    = 1'b0;
    #12;
    chk("rst_we",    vrf_we_o, 0);
    chk("rst_ready", res_ready_o, 1);
    chk("rst_busy",  busy_o, 0);
    chk("rst_done",  wb_done_o, 0);
    chk("rst_tiles", tile_count_o, 0);
    chk("rst_sat",   sat_flag_o, 0);
    chk("rst_drop",  drop_err_o, 0);
    chk("rst_wdata", vrf_wdata_o, 0);
    chk("rst_waddr", vrf_waddr_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // T1: saturation of each lane direction, write held until granted
    cfg_shift_i  = 6'd0;
    cfg_sat_en_i = 1'b1;
    send(5'd3, lanes(64'd5, 64'hFFFF_FFFF_FFFF_FFFD, 64'h1_0000_0000, 64'hFFFF_FFFF_7000_0000));
    @(negedge clk_i);
    chk("t1_we",    vrf_we_o, 1);
    chk("t1_addr",  vrf_waddr_o, 3);
    chk("t1_data",  vrf_wdata_o, exp4(32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000));
    chk("t1_mask",  vrf_wmask_o, 8'h0F);
    chk("t1_sat",   sat_flag_o, 1);
    chk("t1_busy",  busy_o, 1);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("t1_hold_we",   vrf_we_o, 1);
    chk("t1_hold_data", vrf_wdata_o, exp4(32'd5, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000));
    vrf_gnt_i = 1'b1;
    @(posedge clk_i); #1;
    vrf_gnt_i = 1'b0;
    @(negedge clk_i);
    chk("t1_popped", vrf_we_o, 0);
    chk("t1_tiles",  tile_count_o, 1);
    @(posedge clk_i); #1;

    // clear with a same-cycle tile: tile discarded, flags cleared
    res_valid_i = 1'b1;
    res_addr_i  = 5'd1;
    res_data_i  = lanes(64'h1_0000_0000, 0, 0, 0);
    do_clear();
    res_valid_i = 1'b0;
    res_data_i  = '0;
    @(negedge clk_i);
    chk("clr_we",    vrf_we_o, 0);
    chk("clr_sat",   sat_flag_o, 0);
    chk("clr_busy",  busy_o, 0);
    chk("clr_tiles", tile_count_o, 0);
    @(posedge clk_i); #1;

    // T2: truncation without saturation
    cfg_sat_en_i = 1'b0;
    vrf_gnt_i    = 1'b1;
    send(5'd7, lanes(64'h1_2345_6789, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 0));
    @(negedge clk_i);
    chk("t2_data", vrf_wdata_o, exp4(32'h2345_6789, 32'hFFFF_FFFF, 32'h0000_0001, 32'd0));
    chk("t2_addr", vrf_waddr_o, 7);
    chk("t2_sat",  sat_flag_o, 0);
    @(posedge clk_i); #1;
    do_clear();

    // T3: shift by one, with and without rounding
    cfg_shift_i  = 6'd1;
    cfg_sat_en_i = 1'b1;
    send(5'd2, lanes(64'd7, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1_0000_0000, 64'hFFFF_FFFF_0000_0000));
    @(negedge clk_i);
`ifdef MATMUL_WB_ROUND_EN
    chk("t3_data", vrf_wdata_o, exp4(32'd4, 32'hFFFF_FFFD, 32'h7FFF_FFFF, 32'h8000_0000));
`else
    chk("t3_data", vrf_wdata_o, exp4(32'd3, 32'hFFFF_FFFC, 32'h7FFF_FFFF, 32'h8000_0000));
`endif
    chk("t3_sat", sat_flag_o, 1);
    @(posedge clk_i); #1;
    do_clear();

    // T4: overflow drops the fifth tile, then drain in order
    cfg_shift_i  = 6'd0;
    cfg_sat_en_i = 1'b0;
    vrf_gnt_i    = 1'b0;
    for (int k = 0; k < 5; k++) begin
      res_valid_i = 1'b1;
      res_addr_i  = 5'(10 + k);
      res_data_i  = lanes(64'(10 + k), 0, 0, 0);
      @(negedge clk_i);
      if (k == 4) chk("t4_ready_full", res_ready_o, 0);
      @(posedge clk_i); #1;
    end
    res_valid_i = 1'b0;
    res_data_i  = '0;
    vrf_gnt_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      if (k == 0) chk("t4_drop", drop_err_o, 1);
      chk("t4_addr", vrf_waddr_o, 5'(10 + k));
      chk("t4_data", vrf_wdata_o, exp4(32'(10 + k), 0, 0, 0));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("t4_empty", vrf_we_o, 0);
    chk("t4_tiles", tile_count_o, 4);
    @(posedge clk_i); #1;
    do_clear();

    // T5: completion pulse one cycle after the last grant
    vrf_gnt_i = 1'b1;
    for (int c = 0; c < 8; c++) begin
      res_valid_i = (c < 4);
      res_addr_i  = 5'(20 + c);
      res_data_i  = (c < 4) ? lanes(64'(c), 0, 0, 0) : '0;
      mm_done_i   = (c == 3);
      @(negedge clk_i);
      chk("t5_wb_done", wb_done_o, (c == 5));
      if (c == 4) chk("t5_last_addr", vrf_waddr_o, 23);
      if (c == 5) chk("t5_tiles", tile_count_o, 4);
      if (c == 6) chk("t5_idle", busy_o, 0);
      @(posedge clk_i); #1;
    end
    res_valid_i = 1'b0;
    mm_done_i   = 1'b0;
    do_clear();

    // T6: full FIFO with simultaneous push and pop
    vrf_gnt_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(5'(1 + k), lanes(64'(1 + k), 0, 0, 0));
    end
    res_valid_i = 1'b1;
    res_addr_i  = 5'd5;
    res_data_i  = lanes(64'd5, 0, 0, 0);
    vrf_gnt_i   = 1'b1;
    @(negedge clk_i);
    chk("t6_ready", res_ready_o, 1);
    chk("t6_head",  vrf_waddr_o, 1);
    @(posedge clk_i); #1;
    res_valid_i = 1'b0;
    res_data_i  = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      chk("t6_addr", vrf_waddr_o, 5'(2 + k));
      @(posedge clk_i); #1;
    end
    @(negedge clk_i);
    chk("t6_nodrop", drop_err_o, 0);
    chk("t6_empty",  vrf_we_o, 0);
    chk("t6_tiles",  tile_count_o, 5);
    @(posedge clk_i); #1;

    // asynchronous reset while a write is held
    vrf_gnt_i = 1'b0;
    send(5'd9, lanes(64'd9, 0, 0, 0));
    @(negedge clk_i);
    chk("rh_we_before", vrf_we_o, 1);
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk("rh_we",    vrf_we_o, 0);
    chk("rh_busy",  busy_o, 0);
    chk("rh_ready", res_ready_o, 1);
    #3;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("rh_we_after",   vrf_we_o, 0);
    chk("rh_busy_after", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
